// File: rtl/gain_stage_db_if.sv
// Bus bundle for gain_stage_db: audio sample path, BCD gain load strobe, status flags and FSM debug taps.
// gain_load is a one-cycle strobe; the block takes it only in IDLE or RAMP (busy=0) and drops it otherwise.
interface gain_stage_db_if;
  logic signed [15:0] inWave;
  logic               gain_load;
  logic               neg;
  logic [3:0]         num2;
  logic [3:0]         num1;
  logic [3:0]         num0;
  logic signed [15:0] outWave;
  logic               busy;
  logic               ramping;
  logic               bcd_err;
  logic               clip;
  logic [2:0]         dbg_state;
  logic [23:0]        dbg_cur_gain;
  logic [23:0]        dbg_tgt_gain;

  modport master (
    output inWave, gain_load, neg, num2, num1, num0,
    input  outWave, busy, ramping, bcd_err, clip, dbg_state, dbg_cur_gain, dbg_tgt_gain
  );

  modport slave (
    input  inWave, gain_load, neg, num2, num1, num0,
    output outWave, busy, ramping, bcd_err, clip, dbg_state, dbg_cur_gain, dbg_tgt_gain
  );
endinterface

// File: rtl/gain_stage_db.sv
// Gain stage in tenths of dB: BCD setting -> clamped Q5.19 linear gain -> round/saturate multiply.
// Optional macro GAIN_RAMP_EN: glide cur_gain toward the target instead of jumping in one clock.
module gain_stage_db #(
  parameter int RAMP_SHIFT = 6
) (
  input  logic            clk_48,
  input  logic            reset_n,
  gain_stage_db_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BCD    = 3'd1,
    S_CLAMP  = 3'd2,
    S_DIVMOD = 3'd3,
    S_LOOKUP = 3'd4,
    S_RAMP   = 3'd5
  } state_t;

  localparam logic [23:0] UNITY = 24'd524288;

  state_t             state_q;
  logic               neg_q;
  logic [3:0]         n2_q, n1_q, n0_q;
  logic signed [11:0] t_q;
  logic [9:0]         u_q;
  logic [3:0]         q_q;
  logic [23:0]        cur_q, tgt_q;
  logic               busy_q, ramping_q, bcd_err_q;

  logic signed [40:0] p_q;
  logic signed [15:0] out_q;
  logic               clip_q;

  // T[k] = round(16384 * 10^(k/200)): one 0.1 dB step inside a 6 dB octave.
  function automatic logic [14:0] rom_lookup(input logic [5:0] idx);
    case (idx)
      6'd0:  return 15'd16384;  6'd1:  return 15'd16574;  6'd2:  return 15'd16766;
      6'd3:  return 15'd16960;  6'd4:  return 15'd17156;  6'd5:  return 15'd17355;
      6'd6:  return 15'd17556;  6'd7:  return 15'd17759;  6'd8:  return 15'd17965;
      6'd9:  return 15'd18173;  6'd10: return 15'd18383;  6'd11: return 15'd18596;
      6'd12: return 15'd18811;  6'd13: return 15'd19029;  6'd14: return 15'd19250;
      6'd15: return 15'd19472;  6'd16: return 15'd19698;  6'd17: return 15'd19926;
      6'd18: return 15'd20157;  6'd19: return 15'd20390;  6'd20: return 15'd20626;
      6'd21: return 15'd20865;  6'd22: return 15'd21107;  6'd23: return 15'd21351;
      6'd24: return 15'd21598;  6'd25: return 15'd21848;  6'd26: return 15'd22101;
      6'd27: return 15'd22357;  6'd28: return 15'd22616;  6'd29: return 15'd22878;
      6'd30: return 15'd23143;  6'd31: return 15'd23411;  6'd32: return 15'd23682;
      6'd33: return 15'd23956;  6'd34: return 15'd24234;  6'd35: return 15'd24514;
      6'd36: return 15'd24798;  6'd37: return 15'd25085;  6'd38: return 15'd25376;
      6'd39: return 15'd25670;  6'd40: return 15'd25967;  6'd41: return 15'd26268;
      6'd42: return 15'd26572;  6'd43: return 15'd26879;  6'd44: return 15'd27191;
      6'd45: return 15'd27506;  6'd46: return 15'd27824;  6'd47: return 15'd28146;
      6'd48: return 15'd28472;  6'd49: return 15'd28802;  6'd50: return 15'd29135;
      6'd51: return 15'd29473;  6'd52: return 15'd29814;  6'd53: return 15'd30159;
      6'd54: return 15'd30508;  6'd55: return 15'd30862;  6'd56: return 15'd31219;
      6'd57: return 15'd31581;  6'd58: return 15'd31946;  6'd59: return 15'd32316;
      default: return 15'd0;
    endcase
  endfunction

  logic               bcd_bad;
  logic [11:0]        mag;
  logic signed [11:0] t_cl;
  logic [9:0]         u_start;
  logic signed [4:0]  s_val;
  logic [23:0]        lut_ext;
  logic [23:0]        gain_lut;

  always_comb begin
    bcd_bad = (n2_q > 4'd9) || (n1_q > 4'd9) || (n0_q > 4'd9);
    mag     = 12'(n2_q) * 12'd100 + 12'(n1_q) * 12'd10 + 12'(n0_q);
    t_cl    = t_q;
    if (t_q < -12'sd600)     t_cl = -12'sd600;
    else if (t_q > 12'sd240) t_cl = 12'sd240;
    u_start = 10'(t_cl + 12'sd600);
    // Octave index q runs 0..14 around 0 dB at q=10; T[] itself sits at 2^14, hence the -5 bias.
    s_val   = $signed({1'b0, q_q}) - 5'sd5;
    lut_ext = 24'(rom_lookup(u_q[5:0]));
    if (s_val[4]) gain_lut = lut_ext >> 4'(-s_val);
    else          gain_lut = lut_ext << s_val[3:0];
  end

`ifdef GAIN_RAMP_EN
  logic signed [24:0] diff;
  logic signed [24:0] step;

  always_comb begin
    diff = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
    step = diff >>> RAMP_SHIFT;
    if (step == 25'sd0) step = diff[24] ? -25'sd1 : 25'sd1;
  end
`endif

  always_ff @(posedge clk_48) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      neg_q     <= 1'b0;
      n2_q      <= 4'd0;
      n1_q      <= 4'd0;
      n0_q      <= 4'd0;
      t_q       <= 12'sd0;
      u_q       <= 10'd0;
      q_q       <= 4'd0;
      cur_q     <= UNITY;
      tgt_q     <= UNITY;
      busy_q    <= 1'b0;
      ramping_q <= 1'b0;
      bcd_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.gain_load) begin
            neg_q     <= bus.neg;
            n2_q      <= bus.num2;
            n1_q      <= bus.num1;
            n0_q      <= bus.num0;
            bcd_err_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_BCD;
          end
        end
        S_BCD: begin
          if (bcd_bad) begin
            bcd_err_q <= 1'b1;
            busy_q    <= 1'b0;
            ramping_q <= 1'b1;
            state_q   <= S_RAMP;
          end else begin
            t_q     <= neg_q ? -$signed(mag) : $signed(mag);
            state_q <= S_CLAMP;
          end
        end
        S_CLAMP: begin
          u_q     <= u_start;
          q_q     <= 4'd0;
          state_q <= S_DIVMOD;
        end
        S_DIVMOD: begin
          if (u_q >= 10'd60) begin
            u_q <= u_q - 10'd60;
            q_q <= q_q + 4'd1;
          end else begin
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          tgt_q     <= gain_lut;
          busy_q    <= 1'b0;
          ramping_q <= 1'b1;
          state_q   <= S_RAMP;
        end
        S_RAMP: begin
          if (bus.gain_load) begin
            neg_q     <= bus.neg;
            n2_q      <= bus.num2;
            n1_q      <= bus.num1;
            n0_q      <= bus.num0;
            bcd_err_q <= 1'b0;
            busy_q    <= 1'b1;
            ramping_q <= 1'b0;
            state_q   <= S_BCD;
          end else if (cur_q == tgt_q) begin
            ramping_q <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
`ifdef GAIN_RAMP_EN
            cur_q     <= 24'($signed({1'b0, cur_q}) + step);
`else
            cur_q     <= tgt_q;
            ramping_q <= 1'b0;
            state_q   <= S_IDLE;
`endif
          end
        end
        default: begin
          busy_q    <= 1'b0;
          ramping_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  logic signed [40:0] a_ext, g_ext, p_rnd;
  logic signed [21:0] y;
  logic signed [15:0] sat;
  logic               clip_d;

  always_comb begin
    a_ext  = 41'(bus.inWave);
    g_ext  = $signed({17'd0, cur_q});
    p_rnd  = p_q + 41'sd262144;
    y      = 22'(p_rnd >>> 19);
    sat    = y[15:0];
    clip_d = 1'b0;
    if (y > 22'sd32767) begin
      sat    = 16'sh7fff;
      clip_d = 1'b1;
    end else if (y < -22'sd32768) begin
      sat    = 16'sh8000;
      clip_d = 1'b1;
    end
  end

  // Two-stage sample pipe: product register, then rounded/saturated output register.
  always_ff @(posedge clk_48) begin
    if (!reset_n) begin
      p_q    <= 41'sd0;
      out_q  <= 16'sd0;
      clip_q <= 1'b0;
    end else begin
      p_q    <= a_ext * g_ext;
      out_q  <= sat;
      clip_q <= clip_d;
    end
  end

  assign bus.outWave      = out_q;
  assign bus.clip         = clip_q;
  assign bus.busy         = busy_q;
  assign bus.ramping      = ramping_q;
  assign bus.bcd_err      = bcd_err_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_cur_gain = cur_q;
  assign bus.dbg_tgt_gain = tgt_q;

endmodule

// File: tb/tb_gain_stage_db.sv
// Directed bench for gain_stage_db: reset, streaming latency, gain loads, clamping, BCD errors, aborts.
module tb_gain_stage_db;

  logic clk_48 = 1'b0;
  logic reset_n;
  always #5 clk_48 = ~clk_48;

  gain_stage_db_if bus();

  gain_stage_db #(.RAMP_SHIFT(4)) dut (
    .clk_48  (clk_48),
    .reset_n (reset_n),
    .bus     (bus)
  );

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_BCD    = 3'd1;
  localparam logic [2:0] S_DIVMOD = 3'd3;
  localparam logic [2:0] S_RAMP   = 3'd5;

  int n_cmp = 0;
  int n_err = 0;

  task automatic drive_load(input logic ng, input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    @(posedge clk_48); #1;
    bus.neg = ng; bus.num2 = d2; bus.num1 = d1; bus.num0 = d0;
    bus.gain_load = 1'b1;
    @(posedge clk_48); #1;
    bus.gain_load = 1'b0;
  endtask

  task automatic wait_idle(output bit ok, output int rc);
    ok = 1'b0;
    rc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (bus.dbg_state == S_IDLE) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk_48); #1;
      if (bus.ramping) rc++;
    end
  endtask

  task automatic settle(input logic signed [15:0] v);
    bus.inWave = v;
    repeat (3) @(posedge clk_48);
    #1;
  endtask

  task automatic test_reset;
    @(posedge clk_48); #1;
    reset_n = 1'b0;
    bus.inWave = 16'sd1000;
    repeat (2) @(posedge clk_48);
    #1;
    n_cmp++; if (bus.outWave !== 16'sd0) begin n_err++; $display("FAIL reset_out got %0d exp 0", bus.outWave); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.ramping !== 1'b0) begin n_err++; $display("FAIL reset_ramping got %b exp 0", bus.ramping); end
    n_cmp++; if (bus.clip !== 1'b0) begin n_err++; $display("FAIL reset_clip got %b exp 0", bus.clip); end
    n_cmp++; if (bus.bcd_err !== 1'b0) begin n_err++; $display("FAIL reset_bcd_err got %b exp 0", bus.bcd_err); end
    n_cmp++; if (bus.dbg_state !== S_IDLE) begin n_err++; $display("FAIL reset_state got %0d exp 0", bus.dbg_state); end
    n_cmp++; if (bus.dbg_cur_gain !== 24'd524288) begin n_err++; $display("FAIL reset_cur got %0d exp 524288", bus.dbg_cur_gain); end
    n_cmp++; if (bus.dbg_tgt_gain !== 24'd524288) begin n_err++; $display("FAIL reset_tgt got %0d exp 524288", bus.dbg_tgt_gain); end
    reset_n = 1'b1;
    @(posedge clk_48); #1;
    n_cmp++; if (bus.outWave !== 16'sd0) begin n_err++; $display("FAIL reset_lat1 got %0d exp 0", bus.outWave); end
    @(posedge clk_48); #1;
    n_cmp++; if (bus.outWave !== 16'sd1000) begin n_err++; $display("FAIL reset_lat2 got %0d exp 1000", bus.outWave); end
    n_cmp++; if (bus.clip !== 1'b0) begin n_err++; $display("FAIL reset_lat2_clip got %b exp 0", bus.clip); end
  endtask

  task automatic test_back_to_back;
    logic signed [15:0] vec [8];
    logic [15:0] exp_q[$];
    logic [15:0] e;
    vec = '{16'sd1000, -16'sd2000, 16'sd3, 16'sd32767, -16'sd32768, -16'sd1, 16'sd0, 16'sd12345};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_48); #1;
      if (i >= 2) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.outWave !== e) begin n_err++; $display("FAIL b2b_out[%0d] got %0d exp %0d", i - 2, bus.outWave, $signed(e)); end
        n_cmp++; if (bus.clip !== 1'b0) begin n_err++; $display("FAIL b2b_clip[%0d] got %b exp 0", i - 2, bus.clip); end
      end
      if (i < 8) begin
        bus.inWave = vec[i];
        exp_q.push_back(vec[i]);
      end
    end
  endtask

  task automatic test_gain_6db;
    bit ok; int rc;
    drive_load(1'b0, 4'd0, 4'd6, 4'd0);
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL g6_busy got %b exp 1", bus.busy); end
    n_cmp++; if (bus.dbg_state !== S_BCD) begin n_err++; $display("FAIL g6_state got %0d exp 1", bus.dbg_state); end
    wait_idle(ok, rc);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL g6_timeout got %b exp 1", ok); end
`ifndef GAIN_RAMP_EN
    n_cmp++; if (rc !== 1) begin n_err++; $display("FAIL g6_ramp_cycles got %0d exp 1", rc); end
`endif
    n_cmp++; if (bus.dbg_tgt_gain !== 24'd1048576) begin n_err++; $display("FAIL g6_tgt got %0d exp 1048576", bus.dbg_tgt_gain); end
    n_cmp++; if (bus.dbg_cur_gain !== 24'd1048576) begin n_err++; $display("FAIL g6_cur got %0d exp 1048576", bus.dbg_cur_gain); end
    settle(16'sd1000);
    n_cmp++; if (bus.outWave !== 16'sd2000) begin n_err++; $display("FAIL g6_out_pos got %0d exp 2000", bus.outWave); end
    settle(-16'sd7);
    n_cmp++; if (bus.outWave !== -16'sd14) begin n_err++; $display("FAIL g6_out_neg got %0d exp -14", bus.outWave); end
  endtask

  task automatic test_neg20;
    bit ok; int rc;
    drive_load(1'b1, 4'd2, 4'd0, 4'd0);
    wait_idle(ok, rc);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL n20_timeout got %b exp 1", ok); end
    n_cmp++; if (bus.dbg_tgt_gain !== 24'd51934) begin n_err++; $display("FAIL n20_tgt got %0d exp 51934", bus.dbg_tgt_gain); end
    settle(16'sd10000);
    n_cmp++; if (bus.outWave !== 16'sd991) begin n_err++; $display("FAIL n20_out_pos got %0d exp 991", bus.outWave); end
    // (-519340000 + 2^18) >>> 19 floors -990.06 to -991.
    settle(-16'sd10000);
    n_cmp++; if (bus.outWave !== -16'sd991) begin n_err++; $display("FAIL n20_out_neg got %0d exp -991", bus.outWave); end
    n_cmp++; if (bus.clip !== 1'b0) begin n_err++; $display("FAIL n20_clip got %b exp 0", bus.clip); end
  endtask

  task automatic test_clamp;
    bit ok; int rc;
    drive_load(1'b0, 4'd9, 4'd9, 4'd9);
    wait_idle(ok, rc);
    n_cmp++; if (bus.dbg_tgt_gain !== 24'd8388608) begin n_err++; $display("FAIL clamp_hi_tgt got %0d exp 8388608", bus.dbg_tgt_gain); end
    settle(16'sd4000);
    n_cmp++; if (bus.outWave !== 16'sd32767) begin n_err++; $display("FAIL clamp_sat_pos got %0d exp 32767", bus.outWave); end
    n_cmp++; if (bus.clip !== 1'b1) begin n_err++; $display("FAIL clamp_clip_pos got %b exp 1", bus.clip); end
    settle(-16'sd4000);
    n_cmp++; if (bus.outWave !== -16'sd32768) begin n_err++; $display("FAIL clamp_sat_neg got %0d exp -32768", bus.outWave); end
    n_cmp++; if (bus.clip !== 1'b1) begin n_err++; $display("FAIL clamp_clip_neg got %b exp 1", bus.clip); end
    settle(16'sd100);
    n_cmp++; if (bus.outWave !== 16'sd1600) begin n_err++; $display("FAIL clamp_x16 got %0d exp 1600", bus.outWave); end
    n_cmp++; if (bus.clip !== 1'b0) begin n_err++; $display("FAIL clamp_noclip got %b exp 0", bus.clip); end
    drive_load(1'b1, 4'd9, 4'd9, 4'd9);
    wait_idle(ok, rc);
    n_cmp++; if (bus.dbg_tgt_gain !== 24'd512) begin n_err++; $display("FAIL clamp_lo_tgt got %0d exp 512", bus.dbg_tgt_gain); end
    settle(16'sd30000);
    n_cmp++; if (bus.outWave !== 16'sd29) begin n_err++; $display("FAIL clamp_lo_out got %0d exp 29", bus.outWave); end
    drive_load(1'b0, 4'd2, 4'd4, 4'd0);
    wait_idle(ok, rc);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL clamp_timeout got %b exp 1", ok); end
    n_cmp++; if (bus.dbg_tgt_gain !== 24'd8388608) begin n_err++; $display("FAIL clamp_p24_tgt got %0d exp 8388608", bus.dbg_tgt_gain); end
  endtask

  task automatic test_bcd_err;
    bit ok; int rc;
    drive_load(1'b0, 4'd0, 4'hA, 4'd0);
    wait_idle(ok, rc);
    n_cmp++; if (bus.bcd_err !== 1'b1) begin n_err++; $display("FAIL bcd_err_set got %b exp 1", bus.bcd_err); end
    n_cmp++; if (rc !== 1) begin n_err++; $display("FAIL bcd_ramp_cycles got %0d exp 1", rc); end
    n_cmp++; if (bus.dbg_tgt_gain !== 24'd8388608) begin n_err++; $display("FAIL bcd_tgt_kept got %0d exp 8388608", bus.dbg_tgt_gain); end
    settle(16'sd1000);
    n_cmp++; if (bus.outWave !== 16'sd16000) begin n_err++; $display("FAIL bcd_out_kept got %0d exp 16000", bus.outWave); end
    drive_load(1'b0, 4'd0, 4'd0, 4'd0);
    n_cmp++; if (bus.bcd_err !== 1'b0) begin n_err++; $display("FAIL bcd_err_clear got %b exp 0", bus.bcd_err); end
    wait_idle(ok, rc);
    n_cmp++; if (bus.dbg_tgt_gain !== 24'd524288) begin n_err++; $display("FAIL bcd_reload_tgt got %0d exp 524288", bus.dbg_tgt_gain); end
    settle(16'sd1000);
    n_cmp++; if (bus.outWave !== 16'sd1000) begin n_err++; $display("FAIL bcd_reload_out got %0d exp 1000", bus.outWave); end
  endtask

  task automatic test_ignore_busy;
    bit ok; int rc;
    drive_load(1'b0, 4'd0, 4'd6, 4'd0);
    bus.neg = 1'b1; bus.num2 = 4'd2; bus.num1 = 4'd0; bus.num0 = 4'd0;
    bus.gain_load = 1'b1;
    @(posedge clk_48); #1;
    bus.gain_load = 1'b0;
    wait_idle(ok, rc);
    n_cmp++; if (bus.dbg_tgt_gain !== 24'd1048576) begin n_err++; $display("FAIL ignore_busy_tgt got %0d exp 1048576", bus.dbg_tgt_gain); end
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 1'b0;
    drive_load(1'b1, 4'd2, 4'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      if (bus.dbg_state == S_DIVMOD) begin
        found = 1'b1;
        break;
      end
      @(posedge clk_48); #1;
    end
    n_cmp++; if (found !== 1'b1) begin n_err++; $display("FAIL rmid_reach_divmod got %b exp 1", found); end
    reset_n = 1'b0;
    @(posedge clk_48); #1;
    reset_n = 1'b1;
    n_cmp++; if (bus.dbg_state !== S_IDLE) begin n_err++; $display("FAIL rmid_state got %0d exp 0", bus.dbg_state); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b exp 0", bus.busy); end
    n_cmp++; if (bus.dbg_tgt_gain !== 24'd524288) begin n_err++; $display("FAIL rmid_tgt got %0d exp 524288", bus.dbg_tgt_gain); end
    n_cmp++; if (bus.dbg_cur_gain !== 24'd524288) begin n_err++; $display("FAIL rmid_cur got %0d exp 524288", bus.dbg_cur_gain); end
    repeat (3) @(posedge clk_48);
    #1;
    n_cmp++; if (bus.dbg_state !== S_IDLE) begin n_err++; $display("FAIL rmid_stays_idle got %0d exp 0", bus.dbg_state); end
    settle(-16'sd1234);
    n_cmp++; if (bus.outWave !== -16'sd1234) begin n_err++; $display("FAIL rmid_out got %0d exp -1234", bus.outWave); end
  endtask

`ifdef GAIN_RAMP_EN
  task automatic test_ramp;
    bit ok; int rc; int bad; bit rs; logic [23:0] pc; logic [23:0] frozen;
    bad = 0;
    drive_load(1'b1, 4'd6, 4'd0, 4'd0);
    for (int i = 0; i < 3000; i++) begin
      rs = (bus.dbg_state == S_RAMP);
      pc = bus.dbg_cur_gain;
      @(posedge clk_48); #1;
      if (rs && pc != 24'd512 && !(bus.dbg_cur_gain < pc)) bad++;
      if (bus.dbg_state == S_IDLE) break;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL ramp_down_monotone got %0d exp 0", bad); end
    n_cmp++; if (bus.dbg_cur_gain !== 24'd512) begin n_err++; $display("FAIL ramp_down_final got %0d exp 512", bus.dbg_cur_gain); end
    drive_load(1'b0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 20 && bus.dbg_state != S_RAMP; i++) begin
      @(posedge clk_48); #1;
    end
    repeat (10) @(posedge clk_48);
    #1;
    drive_load(1'b1, 4'd6, 4'd0, 4'd0);
    frozen = bus.dbg_cur_gain;
    repeat (3) @(posedge clk_48);
    #1;
    n_cmp++; if (bus.dbg_cur_gain !== frozen) begin n_err++; $display("FAIL ramp_frozen got %0d exp %0d", bus.dbg_cur_gain, frozen); end
    n_cmp++; if (frozen <= 24'd512) begin n_err++; $display("FAIL ramp_reversed got %0d exp above 512", frozen); end
    wait_idle(ok, rc);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ramp_timeout got %b exp 1", ok); end
    n_cmp++; if (bus.dbg_cur_gain !== 24'd512) begin n_err++; $display("FAIL ramp_final got %0d exp 512", bus.dbg_cur_gain); end
  endtask
`endif

  initial begin
    reset_n       = 1'b0;
    bus.inWave    = 16'sd0;
    bus.gain_load = 1'b0;
    bus.neg       = 1'b0;
    bus.num2      = 4'd0;
    bus.num1      = 4'd0;
    bus.num0      = 4'd0;
    test_reset();
    test_back_to_back();
    test_gain_6db();
    test_neg20();
    test_clamp();
    test_bcd_err();
    test_ignore_busy();
    test_reset_mid();
`ifdef GAIN_RAMP_EN
    test_ramp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
